// File: rtl/bitonic_sorted_serializer.sv
// bitonic_sorted_serializer
//   Takes one sorted 8-element vector per handshake from the bitonic
//   final-merge stage and stores it in one bank of a two-bank ping-pong
//   buffer. Elements stream out one per cycle. A new vector can load into
//   the free bank while the other bank drains, so the block sustains
//   8 elements per 8 cycles.
//
// Parameters
//   DATA_W  element width
//   ASCEND  0: number_in1 (largest) leaves first; 1: number_in8 (smallest) first
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   number_in1..number_in8     sorted vector, in1 largest, in8 smallest
//   in_valid / in_ready        input handshake
//   out_data / out_valid /
//   out_ready                  output handshake
//   out_idx                    position of out_data within its vector
//   out_last                   high with the 8th element of a vector
//   busy                       at least one bank holds data
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready and all out_* signals come from registers only, so
// neither side sees a combinational path from the other side's inputs.
module bitonic_sorted_serializer #(
    parameter int DATA_W = 8,
    parameter bit ASCEND = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] number_in1,
    input  logic [DATA_W-1:0] number_in2,
    input  logic [DATA_W-1:0] number_in3,
    input  logic [DATA_W-1:0] number_in4,
    input  logic [DATA_W-1:0] number_in5,
    input  logic [DATA_W-1:0] number_in6,
    input  logic [DATA_W-1:0] number_in7,
    input  logic [DATA_W-1:0] number_in8,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_idx,
    output logic              out_last,
    output logic              busy
);

    // Banks are stored in emission order, so the read side simply walks
    // element 0..7 regardless of ASCEND.
    logic [1:0][7:0][DATA_W-1:0] bank;
    logic [1:0]                  full;
    logic                        wr_bank;
    logic                        rd_bank;
    logic [2:0]                  idx;

    logic [7:0][DATA_W-1:0] raw_vec;
    logic [7:0][DATA_W-1:0] ordered_vec;
    logic [1:0]             full_next;
    logic                   load;
    logic                   drain;
    logic                   drain_last;

    always_comb begin
        raw_vec[0] = number_in1;
        raw_vec[1] = number_in2;
        raw_vec[2] = number_in3;
        raw_vec[3] = number_in4;
        raw_vec[4] = number_in5;
        raw_vec[5] = number_in6;
        raw_vec[6] = number_in7;
        raw_vec[7] = number_in8;
        ordered_vec = raw_vec;
        if (ASCEND) begin
            for (int k = 0; k < 8; k++) begin
                ordered_vec[k] = raw_vec[7-k];
            end
        end
    end

    assign in_ready   = !full[wr_bank];
    assign out_valid  = full[rd_bank];
    assign out_data   = bank[rd_bank][idx];
    assign out_idx    = idx;
    assign out_last   = out_valid && (idx == 3'd7);
    assign busy       = full[0] | full[1];

    assign load       = in_valid && in_ready;
    assign drain      = out_valid && out_ready;
    assign drain_last = drain && (idx == 3'd7);

    // The load bank is never full and the drain bank always is, so the two
    // updates below always touch different bits of full.
    always_comb begin
        full_next = full;
        if (drain_last) full_next[rd_bank] = 1'b0;
        if (load)       full_next[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank    <= '0;
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            idx     <= 3'd0;
        end else begin
            full <= full_next;
            if (load) begin
                bank[wr_bank] <= ordered_vec;
                wr_bank       <= !wr_bank;
            end
            if (drain) begin
                idx <= idx + 3'd1;
                if (drain_last) begin
                    rd_bank <= !rd_bank;
                end
            end
        end
    end

endmodule
